// File: rtl/mixer_pkg.sv
// Shared definitions for the ternary symbol mixer: level codes, sequencer states
// and the per-channel level resolution helper.
package mixer_pkg;

  localparam logic [1:0] LVL_ZERO = 2'b00;
  localparam logic [1:0] LVL_POS  = 2'b01;
  localparam logic [1:0] LVL_HOLD = 2'b10;
  localparam logic [1:0] LVL_NEG  = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // A HOLD code keeps the channel's previous level; stored levels are never HOLD.
  function automatic logic [1:0] resolve_level(input logic [1:0] code, input logic [1:0] held);
    logic [1:0] lvl;
    case (code)
      LVL_HOLD: lvl = held;
      LVL_ZERO: lvl = LVL_ZERO;
      LVL_POS:  lvl = LVL_POS;
      LVL_NEG:  lvl = LVL_NEG;
      default:  lvl = LVL_ZERO;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/mixer_sym_seq_if.sv
// Symbol, carrier and mixed-output streams of the symbol-sequenced mixer.
interface mixer_sym_seq_if #(
  parameter int DW  = 18,
  parameter int NCH = 2
);
  logic                sym_valid;
  logic                sym_ready;
  logic [2*NCH-1:0]    sym_data;
  logic                car_valid;
  logic [DW*NCH-1:0]   car_data;
  logic                out_valid;
  logic [DW*NCH-1:0]   out_data;
  logic                out_sym_start;

  modport master (
    output sym_valid, sym_data, car_valid, car_data,
    input  sym_ready, out_valid, out_data, out_sym_start
  );

  modport slave (
    input  sym_valid, sym_data, car_valid, car_data,
    output sym_ready, out_valid, out_data, out_sym_start
  );
endinterface

// File: rtl/mixer_lane.sv
// One channel: ternary multiply of a carrier sample by {0,+1,-1} with saturating
// negation, followed by the stage-2 output register.
module mixer_lane
  import mixer_pkg::*;
#(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] car,
  input  logic [1:0]    lvl,
  output logic [DW-1:0] data
);

  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] ONE_VAL = {{(DW-1){1'b0}}, 1'b1};

  // The most negative value has no positive twin, so it clips to the maximum.
  function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    if (x == MIN_VAL) begin
      r = MAX_VAL;
    end else begin
      r = ~x + ONE_VAL;
    end
    return r;
  endfunction

  logic [DW-1:0] prod_s;

  // ternary product
  always_comb begin
    prod_s = {DW{1'b0}};
    case (lvl)
      LVL_POS: prod_s = car;
      LVL_NEG: prod_s = sat_neg(car);
      default: prod_s = {DW{1'b0}};
    endcase
  end

  // stage-2 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= {DW{1'b0}};
    end else if (load) begin
      data <= prod_s;
    end
  end

endmodule

// File: rtl/mixer_sym_seq.sv
// Multi-channel ternary mixer: sequences symbols over a programmable number of
// carrier samples and mixes each sample through a two-stage pipeline.
module mixer_sym_seq
  import mixer_pkg::*;
#(
  parameter int DW    = 18,
  parameter int NCH   = 2,
  parameter int SPS_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SPS_W-1:0] sps,
  input  logic             clr_underrun,
  output logic             underrun,
  mixer_sym_seq_if.slave   bus
);

  localparam logic [SPS_W-1:0] SPS_ZERO = {SPS_W{1'b0}};
  localparam logic [SPS_W-1:0] SPS_ONE  = {{(SPS_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [SPS_W-1:0]  cnt_r, sps_lat_r, sps_eff_s;
  logic              started_r, underrun_r;
  logic [2*NCH-1:0]  lvl_r, lvl_next_s, s1_lvl_r;
  logic [DW*NCH-1:0] s1_car_r, out_data_s;
  logic              s1_valid_r, s1_start_r, out_valid_r, out_sym_start_r;
  logic              car_acc_s, last_s, sym_ready_s, load_s, drop_s;

  // handshake decode and next state
  always_comb begin
    car_acc_s   = en & bus.car_valid & (state_r == ACTIVE);
    last_s      = car_acc_s & (cnt_r == (sps_lat_r - SPS_ONE));
    sym_ready_s = en & ((state_r == IDLE) | last_s);
    load_s      = sym_ready_s & bus.sym_valid;
    drop_s      = en & bus.car_valid & (state_r == IDLE);
    sps_eff_s   = (sps == SPS_ZERO) ? SPS_ONE : sps;
    lvl_next_s  = lvl_r;
    for (int k = 0; k < NCH; k++) begin
      lvl_next_s[2*k +: 2] = resolve_level(bus.sym_data[2*k +: 2], lvl_r[2*k +: 2]);
    end
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) state_s = ACTIVE;
        else        state_s = IDLE;
      end
      ACTIVE: begin
        if (last_s & ~load_s) state_s = IDLE;
        else                  state_s = ACTIVE;
      end
      default: state_s = IDLE;
    endcase
  end

  // symbol sequencer state; a load on the last sample restarts the count seamlessly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= SPS_ZERO;
      sps_lat_r  <= SPS_ONE;
      started_r  <= 1'b0;
      lvl_r      <= {(2*NCH){1'b0}};
      underrun_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        lvl_r     <= lvl_next_s;
        sps_lat_r <= sps_eff_s;
        cnt_r     <= SPS_ZERO;
        started_r <= 1'b1;
      end else if (car_acc_s) begin
        cnt_r <= cnt_r + SPS_ONE;
      end
      if (drop_s & started_r) begin
        underrun_r <= 1'b1;
      end else if (clr_underrun) begin
        underrun_r <= 1'b0;
      end
    end
  end

  // stage 1 and the shared stage-2 flags; everything freezes while en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r      <= 1'b0;
      s1_start_r      <= 1'b0;
      s1_car_r        <= {(DW*NCH){1'b0}};
      s1_lvl_r        <= {(2*NCH){1'b0}};
      out_valid_r     <= 1'b0;
      out_sym_start_r <= 1'b0;
    end else if (en) begin
      s1_valid_r      <= car_acc_s;
      out_valid_r     <= s1_valid_r;
      out_sym_start_r <= s1_valid_r & s1_start_r;
      if (car_acc_s) begin
        s1_car_r   <= bus.car_data;
        s1_lvl_r   <= lvl_r;
        s1_start_r <= (cnt_r == SPS_ZERO);
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    mixer_lane #(.DW(DW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (en & s1_valid_r),
      .car   (s1_car_r[DW*k +: DW]),
      .lvl   (s1_lvl_r[2*k +: 2]),
      .data  (out_data_s[DW*k +: DW])
    );
  end

  assign bus.sym_ready     = sym_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_data      = out_data_s;
  assign bus.out_sym_start = out_sym_start_r;
  assign underrun          = underrun_r;

endmodule

// File: tb/tb_mixer_sym_seq.sv
// Directed scoreboard bench for mixer_sym_seq: expected samples are queued when
// carrier data is driven and checked (value, start flag, arrival edge) on output.
module tb_mixer_sym_seq;

  localparam int DW    = 18;
  localparam int NCH   = 2;
  localparam int SPS_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [SPS_W-1:0] sps;
  logic             clr_underrun;
  logic             underrun;

  mixer_sym_seq_if #(.DW(DW), .NCH(NCH)) bus ();

  mixer_sym_seq #(.DW(DW), .NCH(NCH), .SPS_W(SPS_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sps          (sps),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp_cyc;
    int d0;
    int d1;
    bit st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   act_cnt = 0;
  logic en_q;
  logic [DW*NCH-1:0] snap_data;
  logic              snap_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // count enabled clock edges so the scoreboard can pin output latency
  always @(posedge clk) begin
    en_q <= en;
    if (en === 1'b1) act_cnt <= act_cnt + 1;
  end

  // a new output sample appears only on an edge where en was high
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && en_q === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_edge",  act_cnt, mon_e.exp_cyc);
        chk("out_ch0",   $signed(bus.out_data[DW-1:0]), mon_e.d0);
        chk("out_ch1",   $signed(bus.out_data[2*DW-1:DW]), mon_e.d1);
        chk("out_start", bus.out_sym_start, mon_e.st);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_car(input int c0, input int c1);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = c0[DW-1:0];
    b = c1[DW-1:0];
    bus.car_valid = 1'b1;
    bus.car_data  = {b, a};
  endtask

  task automatic push_exp(input int d0, input int d1, input bit st);
    exp_t e;
    e.exp_cyc = act_cnt + 2;
    e.d0 = d0;
    e.d1 = d1;
    e.st = st;
    sb.push_back(e);
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    #1;
    chk(tag, bus.sym_ready, exp);
  endtask

  task automatic load_sym(input string tag, input logic [3:0] code, input logic [SPS_W-1:0] s);
    bus.sym_valid = 1'b1;
    bus.sym_data  = code;
    sps           = s;
    chk_ready(tag, 1'b1);
    step();
    bus.sym_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sps = '0; clr_underrun = 1'b0;
    bus.sym_valid = 1'b0; bus.sym_data = '0; bus.car_valid = 1'b0; bus.car_data = '0;
    repeat (2) step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data",  bus.out_data, '0);
    chk("rst_out_start", bus.out_sym_start, 1'b0);
    chk("rst_underrun",  underrun, 1'b0);
    chk("rst_ready_en0", bus.sym_ready, 1'b0);
    reset = 1'b0; en = 1'b1;
    step();

    // 1: ch0 +, ch1 -, sps=4
    load_sym("t1_ready_idle", 4'b1101, 8'd4);
    for (int i = 0; i < 4; i++) begin
      drive_car(100, 200);
      push_exp(100, -200, i == 0);
      if (i == 0) chk_ready("t1_ready_mid", 1'b0);
      if (i == 3) chk_ready("t1_ready_last", 1'b1);
      step();
    end
    bus.car_valid = 1'b0;
    repeat (3) step();

    // 2: saturating negation and zero level
    load_sym("t2_ready_idle", 4'b0011, 8'd2);
    drive_car(-131072, 5);  push_exp(131071, 0, 1'b1); step();
    drive_car(7, -131072);  push_exp(-7, 0, 1'b0);     step();
    bus.car_valid = 1'b0;
    repeat (3) step();

    // 3: back-to-back symbols, second one offered early
    load_sym("t3_ready_idle", 4'b0101, 8'd2);
    bus.sym_valid = 1'b1; bus.sym_data = 4'b1011;
    drive_car(10, 1001); push_exp(10, 1001, 1'b1); chk_ready("t3_ready_s1", 1'b0); step();
    sps = 8'd3;
    drive_car(20, 1002); push_exp(20, 1002, 1'b0); chk_ready("t3_ready_s2", 1'b1); step();
    bus.sym_valid = 1'b0;
    drive_car(30, 1003); push_exp(-30, 1003, 1'b1); step();
    drive_car(40, 1004); push_exp(-40, 1004, 1'b0); step();
    drive_car(50, 1005); push_exp(-50, 1005, 1'b0); chk_ready("t3_ready_b_last", 1'b1); step();
    bus.car_valid = 1'b0;
    repeat (3) step();

    // 4: sps=0 acts as 1
    load_sym("t4_ready_idle", 4'b1101, 8'd0);
    bus.sym_valid = 1'b1; bus.sym_data = 4'b0010;
    drive_car(300, 400); push_exp(300, -400, 1'b1); chk_ready("t4_ready_1", 1'b1); step();
    bus.sym_valid = 1'b0;
    drive_car(-500, 600); push_exp(-500, 0, 1'b1); chk_ready("t4_ready_2", 1'b1); step();
    bus.car_valid = 1'b0;
    repeat (3) step();

    // 5: underrun set, set-beats-clear, clear
    chk("t5_underrun_pre", underrun, 1'b0);
    drive_car(1, 2); step();
    chk("t5_underrun_set", underrun, 1'b1);
    clr_underrun = 1'b1; step();
    chk("t5_underrun_set_wins", underrun, 1'b1);
    bus.car_valid = 1'b0; step();
    chk("t5_underrun_clr", underrun, 1'b0);
    clr_underrun = 1'b0;
    step();

    // 6a: stall mid-symbol
    load_sym("t6_ready_idle", 4'b1101, 8'd4);
    drive_car(11, 22); push_exp(11, -22, 1'b1); step();
    drive_car(33, 44); push_exp(33, -44, 1'b0); step();
    en = 1'b0; bus.sym_valid = 1'b1; bus.sym_data = 4'b0000;
    snap_data = bus.out_data; snap_valid = bus.out_valid;
    for (int i = 0; i < 3; i++) begin
      chk_ready("t6_ready_stall", 1'b0);
      step();
      chk("t6_frozen_data", bus.out_data, snap_data);
      chk("t6_frozen_valid", bus.out_valid, snap_valid);
    end
    en = 1'b1; bus.sym_valid = 1'b0;
    drive_car(55, 66); push_exp(55, -66, 1'b0); chk_ready("t6_ready_resume", 1'b0); step();
    drive_car(77, 88); push_exp(77, -88, 1'b0); chk_ready("t6_ready_last", 1'b1); step();
    bus.car_valid = 1'b0;
    repeat (3) step();

    // 6b: reset mid-symbol discards in-flight data and held levels
    load_sym("t6b_ready_idle", 4'b0111, 8'd4);
    drive_car(9, 8); push_exp(-9, 8, 1'b1); step();
    drive_car(7, 6); push_exp(-7, 6, 1'b0); step();
    drive_car(5, 4); step();
    bus.car_valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6b_rst_valid", bus.out_valid, 1'b0);
    chk("t6b_rst_data",  bus.out_data, '0);
    chk("t6b_rst_start", bus.out_sym_start, 1'b0);
    chk("t6b_rst_idle",  bus.sym_ready, 1'b1);
    step(); step();
    reset = 1'b0;
    step();
    drive_car(3, 3); step();
    bus.car_valid = 1'b0;
    chk("t6b_no_underrun_unstarted", underrun, 1'b0);
    load_sym("t6b_ready_after", 4'b0110, 8'd1);
    drive_car(50, 60); push_exp(0, 60, 1'b1); step();
    bus.car_valid = 1'b0;
    repeat (4) step();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
